// File: rtl/vram_snoop_if.sv
// rtl/vram_snoop_if.sv - CPU bus snoop inputs and diagnostics read port of vram_snoop
interface vram_snoop_if #(
    parameter int VRAM_SIZE_LOG2 = 11
);
    logic                      cpu_phi2;
    logic                      cpu_rwb;
    logic [15:0]               cpu_address;
    logic [7:0]                cpu_data;
    logic [VRAM_SIZE_LOG2-1:0] vram_address;
    logic                      vram_read_clock;
    logic [7:0]                vram_data;

    modport master (
        output cpu_phi2, cpu_rwb, cpu_address, cpu_data,
        output vram_address, vram_read_clock,
        input  vram_data
    );

    modport slave (
        input  cpu_phi2, cpu_rwb, cpu_address, cpu_data,
        input  vram_address, vram_read_clock,
        output vram_data
    );
endinterface

// File: rtl/vram_snoop.sv
// rtl/vram_snoop.sv - passive CPU bus monitor mirroring the video window into an internal RAM
module vram_snoop #(
    parameter logic [15:0] VRAM_BASE      = 16'h8000,
    parameter int          VRAM_SIZE_LOG2 = 11,
    parameter logic [7:0]  FILL_BYTE      = 8'h20
) (
    input  logic        fpga_clk,
    input  logic        fpga_reset,
    vram_snoop_if.slave bus,
    output logic        clear_done,
    output logic        snoop_write,
    output logic [15:0] write_count
);
    localparam int DEPTH = 1 << VRAM_SIZE_LOG2;
    localparam logic [VRAM_SIZE_LOG2-1:0] LAST_PTR = {VRAM_SIZE_LOG2{1'b1}};

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    logic                      r_phi2_meta, r_phi2_s, r_phi2_prev;
    logic                      r_rwb_meta, r_rwb_s;
    logic [15:0]               r_sh_addr;
    logic [7:0]                r_sh_data;
    logic                      r_sh_rwb;
    state_t                    r_state;
    logic [VRAM_SIZE_LOG2-1:0] r_ptr;
    logic                      r_clear_done;
    logic                      r_snoop_write;
    logic [15:0]               r_write_count;
    logic [7:0]                r_vram_data;
    logic [7:0]                r_mem [DEPTH];

    logic                      w_phi2_fall;
    logic                      w_in_window;
    logic                      w_commit;
    logic                      w_we;
    logic [VRAM_SIZE_LOG2-1:0] w_waddr;
    logic [7:0]                w_wdata;

    // phi2/rwb are retimed; address and data are sampled raw but only used once
    // phi2_s has been high long enough for them to have settled on the bus.
    always_ff @(posedge fpga_clk) begin
        if (fpga_reset) begin
            r_phi2_meta <= 1'b0;
            r_phi2_s    <= 1'b0;
            r_phi2_prev <= 1'b0;
            r_rwb_meta  <= 1'b1;
            r_rwb_s     <= 1'b1;
            r_sh_addr   <= 16'h0000;
            r_sh_data   <= 8'h00;
            r_sh_rwb    <= 1'b1;
        end else begin
            r_phi2_meta <= bus.cpu_phi2;
            r_phi2_s    <= r_phi2_meta;
            r_phi2_prev <= r_phi2_s;
            r_rwb_meta  <= bus.cpu_rwb;
            r_rwb_s     <= r_rwb_meta;
            if (r_phi2_s) begin
                r_sh_addr <= bus.cpu_address;
                r_sh_data <= bus.cpu_data;
                r_sh_rwb  <= r_rwb_s;
            end
        end
    end

    assign w_phi2_fall = r_phi2_prev & ~r_phi2_s;
    assign w_in_window = (r_sh_addr[15:VRAM_SIZE_LOG2] == VRAM_BASE[15:VRAM_SIZE_LOG2]);
    assign w_commit    = ~fpga_reset & w_phi2_fall & ~r_sh_rwb & w_in_window;

    // Single write port: a bus commit wins over the clear sweep for that cycle.
    assign w_we    = w_commit | (~fpga_reset & (r_state == S_CLEAR));
    assign w_waddr = w_commit ? r_sh_addr[VRAM_SIZE_LOG2-1:0] : r_ptr;
    assign w_wdata = w_commit ? r_sh_data : FILL_BYTE;

    always_ff @(posedge fpga_clk) begin
        if (fpga_reset) begin
            r_state       <= S_CLEAR;
            r_ptr         <= '0;
            r_clear_done  <= 1'b0;
            r_snoop_write <= 1'b0;
            r_write_count <= 16'h0000;
        end else begin
            r_snoop_write <= w_commit;
            if (w_commit) begin
                r_write_count <= r_write_count + 16'd1;
            end
            case (r_state)
                S_CLEAR: begin
                    if (!w_commit) begin
                        if (r_ptr == LAST_PTR) begin
                            r_state      <= S_RUN;
                            r_clear_done <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr + VRAM_SIZE_LOG2'(1);
                        end
                    end
                end
                S_RUN: begin
                    r_state <= S_RUN;
                end
                default: begin
                    r_state <= S_CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge fpga_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Read-before-write: a same-cycle write to the read address returns the old byte.
    always_ff @(posedge fpga_clk) begin
        if (fpga_reset) begin
            r_vram_data <= 8'h00;
        end else if (bus.vram_read_clock) begin
            r_vram_data <= r_mem[bus.vram_address];
        end
    end

    assign bus.vram_data = r_vram_data;
    assign clear_done    = r_clear_done;
    assign snoop_write   = r_snoop_write;
    assign write_count   = r_write_count;
endmodule
